// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared widths, encodings and helpers for the register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int REG_WIDTH    = 5;
  localparam int EX_REG_WIDTH = 6;
  localparam int RoB_WIDTH    = 8;
  localparam int EX_RoB_WIDTH = 9;
  localparam int RoB_SIZE     = 1 << RoB_WIDTH;
  localparam int NUM_REGS     = 1 << REG_WIDTH;
  localparam int XLEN         = 32;

  localparam logic [EX_REG_WIDTH-1:0] NON_REG = 6'b100000;
  localparam logic [EX_RoB_WIDTH-1:0] NON_DEP = 9'b100000000;

  // True for x1..x31; false for x0 and the "no register" encoding.
  function automatic logic is_arch_reg(input logic [EX_REG_WIDTH-1:0] rs);
    return (rs[EX_REG_WIDTH-1] == 1'b0) && (rs[REG_WIDTH-1:0] != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_read_port.sv
// ============================================================================
// Module      : rf_read_port
// Description : One combinational read port; optional commit forwarding
//               enabled by RF_COMMIT_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_read_port
  import riscv_pkg::*;
(
  input  logic [EX_REG_WIDTH-1:0]                i_rs,
  input  logic [NUM_REGS-1:0][EX_RoB_WIDTH-1:0]  i_tags,
  input  logic [NUM_REGS-1:0][XLEN-1:0]          i_values,
  input  logic                                   i_commit_en,
  input  logic [RoB_WIDTH-1:0]                   i_commit_rob,
  input  logic [EX_REG_WIDTH-1:0]                i_commit_rd,
  input  logic [XLEN-1:0]                        i_commit_value,
  output logic [EX_RoB_WIDTH-1:0]                o_q,
  output logic [XLEN-1:0]                        o_v
);

  logic [EX_RoB_WIDTH-1:0] w_tag;
  logic [XLEN-1:0]         w_value;

  assign w_tag   = i_tags[i_rs[REG_WIDTH-1:0]];
  assign w_value = i_values[i_rs[REG_WIDTH-1:0]];

`ifdef RF_COMMIT_BYPASS_EN
  // Forward only when the commit still owns the tag; a younger rename must be seen.
  logic w_bypass;
  assign w_bypass = i_commit_en && (i_commit_rd == i_rs) && (w_tag == {1'b0, i_commit_rob});
`else
  logic w_bypass;
  logic w_unused_commit;
  assign w_bypass        = 1'b0;
  assign w_unused_commit = ^{i_commit_en, i_commit_rob, i_commit_rd, i_commit_value};
`endif

  always_comb begin
    o_q = NON_DEP;
    o_v = '0;
    if (is_arch_reg(i_rs)) begin
      if (w_bypass) begin
        o_q = NON_DEP;
        o_v = i_commit_value;
      end else begin
        o_q = w_tag;
        o_v = w_value;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/register_file.sv
// ============================================================================
// Module      : register_file
// Description : Architectural register file with rename tags, commit and
//               flush; RF_COMMIT_BYPASS_EN enables same-cycle commit forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file
  import riscv_pkg::*;
(
  input  logic                     Sys_clk,
  input  logic                     Sys_rst,
  input  logic                     Sys_rdy,
  input  logic [EX_REG_WIDTH-1:0]  DPRF_rs1,
  input  logic [EX_REG_WIDTH-1:0]  DPRF_rs2,
  output logic [EX_RoB_WIDTH-1:0]  RFDP_Qj,
  output logic [EX_RoB_WIDTH-1:0]  RFDP_Qk,
  output logic [XLEN-1:0]          RFDP_Vj,
  output logic [XLEN-1:0]          RFDP_Vk,
  input  logic                     DPRF_en,
  input  logic [EX_REG_WIDTH-1:0]  DPRF_rd,
  input  logic [RoB_WIDTH-1:0]     DPRF_RoB_index,
  input  logic                     RoBRF_en,
  input  logic [RoB_WIDTH-1:0]     RoBRF_RoB_index,
  input  logic [EX_REG_WIDTH-1:0]  RoBRF_rd,
  input  logic [XLEN-1:0]          RoBRF_value,
  input  logic                     RoBRF_flush
);

  logic [NUM_REGS-1:0][XLEN-1:0]         r_value;
  logic [NUM_REGS-1:0][EX_RoB_WIDTH-1:0] r_tag;

  logic w_rename_ok;
  logic w_commit_ok;

  assign w_rename_ok = DPRF_en && is_arch_reg(DPRF_rd) && !RoBRF_flush;
  assign w_commit_ok = RoBRF_en && is_arch_reg(RoBRF_rd);

  // Rename is applied after commit so that a same-cycle rename keeps its tag.
  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      r_value <= '0;
      r_tag   <= {NUM_REGS{NON_DEP}};
    end else if (Sys_rdy) begin
      if (w_commit_ok) begin
        r_value[RoBRF_rd[REG_WIDTH-1:0]] <= RoBRF_value;
        if (r_tag[RoBRF_rd[REG_WIDTH-1:0]] == {1'b0, RoBRF_RoB_index})
          r_tag[RoBRF_rd[REG_WIDTH-1:0]] <= NON_DEP;
      end
      if (RoBRF_flush)
        r_tag <= {NUM_REGS{NON_DEP}};
      else if (w_rename_ok)
        r_tag[DPRF_rd[REG_WIDTH-1:0]] <= {1'b0, DPRF_RoB_index};
    end
  end

  rf_read_port u_read_j (
    .i_rs           (DPRF_rs1),
    .i_tags         (r_tag),
    .i_values       (r_value),
    .i_commit_en    (RoBRF_en),
    .i_commit_rob   (RoBRF_RoB_index),
    .i_commit_rd    (RoBRF_rd),
    .i_commit_value (RoBRF_value),
    .o_q            (RFDP_Qj),
    .o_v            (RFDP_Vj)
  );

  rf_read_port u_read_k (
    .i_rs           (DPRF_rs2),
    .i_tags         (r_tag),
    .i_values       (r_value),
    .i_commit_en    (RoBRF_en),
    .i_commit_rob   (RoBRF_RoB_index),
    .i_commit_rd    (RoBRF_rd),
    .i_commit_value (RoBRF_value),
    .o_q            (RFDP_Qk),
    .o_v            (RFDP_Vk)
  );

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
// Module      : tb_register_file
// Description : Scoreboard bench for register_file (directed vectors).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file;
  import riscv_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst, rdy;
  logic [EX_REG_WIDTH-1:0] rs1, rs2, drd, crd;
  logic [EX_RoB_WIDTH-1:0] qj, qk;
  logic [XLEN-1:0]         vj, vk, cval;
  logic                    den, cen, flush;
  logic [RoB_WIDTH-1:0]    drob, crob;

  typedef struct {
    string                   name;
    logic [EX_RoB_WIDTH-1:0] qj;
    logic [XLEN-1:0]         vj;
    logic [EX_RoB_WIDTH-1:0] qk;
    logic [XLEN-1:0]         vk;
  } exp_t;

  exp_t exp_q[$];
  logic sample_req = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  register_file dut (
    .Sys_clk         (clk),
    .Sys_rst         (rst),
    .Sys_rdy         (rdy),
    .DPRF_rs1        (rs1),
    .DPRF_rs2        (rs2),
    .RFDP_Qj         (qj),
    .RFDP_Qk         (qk),
    .RFDP_Vj         (vj),
    .RFDP_Vk         (vk),
    .DPRF_en         (den),
    .DPRF_rd         (drd),
    .DPRF_RoB_index  (drob),
    .RoBRF_en        (cen),
    .RoBRF_RoB_index (crob),
    .RoBRF_rd        (crd),
    .RoBRF_value     (cval),
    .RoBRF_flush     (flush)
  );

  // Monitor: outputs are sampled mid-cycle, well clear of the rising edge.
  always @(negedge clk) begin
    if (sample_req) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty: monitor sampled with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        if ({qj, vj, qk, vk} !== {e.qj, e.vj, e.qk, e.vk}) begin
          failures++;
          $display("FAIL %s: got Qj=%h Vj=%h Qk=%h Vk=%h, expected Qj=%h Vj=%h Qk=%h Vk=%h",
                   e.name, qj, vj, qk, vk, e.qj, e.vj, e.qk, e.vk);
        end
      end
    end
  end

  task automatic idle();
    rdy = 1'b1; den = 1'b0; cen = 1'b0; flush = 1'b0;
    rs1 = NON_REG; rs2 = NON_REG; drd = NON_REG; crd = NON_REG;
    drob = '0; crob = '0; cval = '0;
  endtask

  task automatic expect_rd(input string name, input logic [8:0] eqj, input logic [31:0] evj,
                           input logic [8:0] eqk, input logic [31:0] evk);
    exp_t e;
    e.name = name; e.qj = eqj; e.vj = evj; e.qk = eqk; e.vk = evk;
    exp_q.push_back(e);
    sample_req = 1'b1;
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    sample_req = 1'b0;
    idle();
  endtask

  task automatic rename(input logic [5:0] rd, input logic [7:0] rob);
    den = 1'b1; drd = rd; drob = rob;
  endtask

  task automatic commit(input logic [7:0] rob, input logic [5:0] rd, input logic [31:0] v);
    cen = 1'b1; crob = rob; crd = rd; cval = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    rs1 = 6'd5;
    expect_rd("reset_read", NON_DEP, 32'h0, NON_DEP, 32'h0);
    tick();

    // rename x3 -> 7; same-cycle read sees the old tag
    rename(6'd3, 8'd7); rs1 = 6'd3;
    expect_rd("rename_same_cycle_old_tag", NON_DEP, 32'h0, NON_DEP, 32'h0);
    tick();
    rs1 = 6'd3;
    expect_rd("rename_x3_tag", 9'd7, 32'h0, NON_DEP, 32'h0);
    tick();
    commit(8'd7, 6'd3, 32'hDEAD);
    tick();
    rs1 = 6'd3;
    expect_rd("commit_x3", NON_DEP, 32'hDEAD, NON_DEP, 32'h0);
    tick();

    // older commit must not clear a younger rename
    rename(6'd4, 8'd2); tick();
    rename(6'd4, 8'd9); tick();
    commit(8'd2, 6'd4, 32'h11); rs1 = 6'd4;
    expect_rd("stale_commit_same_cycle", 9'd9, 32'h0, NON_DEP, 32'h0);
    tick();
    rs1 = 6'd4; rs2 = 6'd3;
    expect_rd("stale_commit_keeps_tag", 9'd9, 32'h11, NON_DEP, 32'hDEAD);
    tick();

    // same-cycle rename and commit to x6
    rename(6'd6, 8'd4); tick();
    rename(6'd6, 8'd12); commit(8'd4, 6'd6, 32'h55); rs1 = 6'd6;
`ifdef RF_COMMIT_BYPASS_EN
    expect_rd("rename_commit_same_cycle_read", NON_DEP, 32'h55, NON_DEP, 32'h0);
`else
    expect_rd("rename_commit_same_cycle_read", 9'd4, 32'h0, NON_DEP, 32'h0);
`endif
    tick();
    rs1 = 6'd6;
    expect_rd("rename_wins_value_written", 9'd12, 32'h55, NON_DEP, 32'h0);
    tick();

    // flush
    rename(6'd1, 8'd20); tick();
    rename(6'd2, 8'd21); tick();
    rename(6'd9, 8'd22); tick();
    rs1 = 6'd1; rs2 = 6'd9;
    expect_rd("pre_flush_tags", 9'd20, 32'h0, 9'd22, 32'h0);
    tick();
    flush = 1'b1; rename(6'd10, 8'd3); tick();
    rs1 = 6'd2; rs2 = 6'd10;
    expect_rd("flush_x2_x10", NON_DEP, 32'h0, NON_DEP, 32'h0);
    tick();
    rs1 = 6'd9; rs2 = 6'd6;
    expect_rd("flush_x9_x6", NON_DEP, 32'h0, NON_DEP, 32'h55);
    tick();

    // x0 is immutable
    rename(6'd0, 8'd5); commit(8'd5, 6'd0, 32'h77); rs1 = 6'd0; rs2 = 6'd0;
    expect_rd("x0_write_same_cycle", NON_DEP, 32'h0, NON_DEP, 32'h0);
    tick();
    rs1 = 6'd0;
    expect_rd("x0_after_write", NON_DEP, 32'h0, NON_DEP, 32'h0);
    tick();

    // commit forwarding
    rename(6'd7, 8'd8); tick();
    commit(8'd8, 6'd7, 32'hAB); rs1 = 6'd7; rs2 = 6'd7;
`ifdef RF_COMMIT_BYPASS_EN
    expect_rd("commit_bypass", NON_DEP, 32'hAB, NON_DEP, 32'hAB);
`else
    expect_rd("commit_no_bypass", 9'd8, 32'h0, 9'd8, 32'h0);
`endif
    tick();
    rs1 = 6'd7;
    expect_rd("commit_x7", NON_DEP, 32'hAB, NON_DEP, 32'h0);
    tick();

    // Sys_rdy low holds all state
    rdy = 1'b0; rename(6'd11, 8'd30); commit(8'd1, 6'd3, 32'h1234); tick();
    rs1 = 6'd11; rs2 = 6'd3;
    expect_rd("rdy_low_hold", NON_DEP, 32'h0, NON_DEP, 32'hDEAD);
    tick();

    // reset mid-operation overrides everything
    rename(6'd12, 8'd1); tick();
    rst = 1'b1; commit(8'd1, 6'd12, 32'h99); rename(6'd13, 8'd2); tick();
    rst = 1'b0;
    rs1 = 6'd7; rs2 = 6'd12;
    expect_rd("mid_reset_x7_x12", NON_DEP, 32'h0, NON_DEP, 32'h0);
    tick();
    rs1 = 6'd3; rs2 = 6'd13;
    expect_rd("mid_reset_x3_x13", NON_DEP, 32'h0, NON_DEP, 32'h0);
    tick();

    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
